// File: rtl/px_pkg.sv
// Shared constants and FSM state type for the pixel oscillator scan sequencer.
package px_pkg;

    localparam int NUM_PX = 19;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] OSC_ALL_STOP = 5'h1F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_WAIT_ACK
    } state_t;

endpackage

// File: rtl/px_freq_counter.sv
// Selects one raw pixel oscillator, synchronizes it into clk and counts its
// rising edges into a saturating counter.
module px_freq_counter #(
    parameter int NUM_PX = 19,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PX-1:0] clk_px,
    input  logic [ADDR_W-1:0] sel,
    input  logic              clr,
    input  logic              en,
    output logic [CNT_W-1:0]  count
);

    logic       px_sel;
    logic [2:0] sync_q;  // [0],[1]: synchronizer, [2]: previous value for edge detect
    logic       rise;

    assign px_sel = clk_px[sel];
    assign rise   = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            count  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], px_sel};
            if (clr) begin
                count <= '0;
            end else if (en && rise && (count != '1)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/px_scan_sequencer.sv
// Steps through the pixel oscillators one at a time, measures each over a gate
// window and hands every result to the I2C side with a drdy/rd_ack handshake.
module px_scan_sequencer
    import px_pkg::*;
#(
    parameter int NUM_PX     = px_pkg::NUM_PX,
    parameter int ADDR_W     = px_pkg::ADDR_W,
    parameter int CNT_W      = 16,
    parameter int GATE_W     = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cont_en,
    input  logic              single_en,
    input  logic [ADDR_W-1:0] single_addr,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [NUM_PX-1:0] clk_px,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] stop_osc,
    output logic [ADDR_W-1:0] px_addr,
    output logic [CNT_W-1:0]  px_count,
    output logic              drdy,
    output logic              busy,
    output logic              scan_done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W-1:0] start_cur;
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] tmr_q;
    logic              cont_q, single_q;
    logic [CNT_W-1:0]  cnt;
    logic              settle_done, gate_done, last_px, scan_end, meas_clr;

    assign start_cur   = (single_en && (int'(single_addr) < NUM_PX)) ? single_addr : '0;
    assign settle_done = (tmr_q == GATE_W'(SETTLE_CYC - 1));
    assign gate_done   = (tmr_q == (gate_q - GATE_W'(1)));
    assign last_px     = (cur_q == ADDR_W'(NUM_PX - 1));
    assign scan_end    = single_q || (last_px && !cont_q);
    assign meas_clr    = (state_q == S_SETTLE) && (state_d == S_MEASURE);

    assign busy     = (state_q != S_IDLE);
    assign stop_osc = ((state_q == S_SETTLE) || (state_q == S_MEASURE)) ? cur_q
                                                                        : ADDR_W'(OSC_ALL_STOP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_SETTLE;
            S_SETTLE:   if (settle_done) state_d = S_MEASURE;
            S_MEASURE:  if (gate_done) state_d = S_WAIT_ACK;
            S_WAIT_ACK: if (rd_ack) state_d = scan_end ? S_IDLE : S_SETTLE;
            default:    state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // tmr_q restarts on every state change, so it serves as both settle and gate timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            cur_q     <= '0;
            gate_q    <= GATE_W'(1);
            cont_q    <= 1'b0;
            single_q  <= 1'b0;
            px_addr   <= '0;
            px_count  <= '0;
            drdy      <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            scan_done <= 1'b0;
            tmr_q     <= (state_d != state_q) ? '0 : tmr_q + GATE_W'(1);
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        gate_q   <= (gate_len == '0) ? GATE_W'(1) : gate_len;
                        cont_q   <= cont_en;
                        single_q <= single_en;
                        cur_q    <= start_cur;
                    end
                end
                S_MEASURE: begin
                    if (state_d == S_WAIT_ACK) begin
                        px_count <= cnt;
                        px_addr  <= cur_q;
                        drdy     <= 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (rd_ack && !abort) begin
                        drdy <= 1'b0;
                        if (scan_end) scan_done <= 1'b1;
                        else          cur_q     <= last_px ? '0 : cur_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
            if (abort) drdy <= 1'b0;
        end
    end

    px_freq_counter #(
        .NUM_PX (NUM_PX),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clk_px (clk_px),
        .sel    (cur_q),
        .clr    (meas_clr),
        .en     (state_q == S_MEASURE),
        .count  (cnt)
    );

endmodule

// File: tb/tb_px_scan_sequencer.sv
// Bench for px_scan_sequencer: scoreboard of expected (pixel, count) results,
// one task per scenario, plus a narrow-counter instance for saturation.
module tb_px_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, rd_ack = 1'b0;
    logic        cont_en = 1'b0, single_en = 1'b0;
    logic [4:0]  single_addr = '0;
    logic [15:0] gate_len = 16'd1;
    logic [18:0] clk_px = '0;
    logic [4:0]  stop_osc, px_addr;
    logic [15:0] px_count;
    logic        drdy, busy, scan_done;

    logic        s_start = 1'b0, s_abort = 1'b0, s_rd_ack = 1'b0;
    logic [4:0]  s_stop_osc, s_px_addr;
    logic [3:0]  s_px_count;
    logic        s_drdy, s_busy, s_scan_done;

    int          n_checks = 0;
    int          n_fail = 0;
    int          px_period = 10;
    logic [18:0] px_mask = '0;
    int          ph = 0;

    typedef struct {
        logic [4:0] addr;
        int         cnt;
    } exp_t;
    exp_t sb[$];

    px_scan_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cont_en(cont_en),
        .single_en(single_en), .single_addr(single_addr), .gate_len(gate_len),
        .clk_px(clk_px), .rd_ack(rd_ack), .stop_osc(stop_osc), .px_addr(px_addr),
        .px_count(px_count), .drdy(drdy), .busy(busy), .scan_done(scan_done)
    );

    px_scan_sequencer #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .cont_en(cont_en),
        .single_en(single_en), .single_addr(single_addr), .gate_len(gate_len),
        .clk_px(clk_px), .rd_ack(s_rd_ack), .stop_osc(s_stop_osc), .px_addr(s_px_addr),
        .px_count(s_px_count), .drdy(s_drdy), .busy(s_busy), .scan_done(s_scan_done)
    );

    always #5 clk = ~clk;

    // Pixel oscillators: all masked pixels share one waveform of px_period clk cycles
    initial forever begin
        @(negedge clk);
        ph++;
        clk_px = ((ph % px_period) < (px_period / 2)) ? px_mask : '0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1; @(negedge clk); rd_ack = 1'b0;
    endtask

    task automatic wait_drdy(input int bound, output int waited);
        waited = 0;
        while (!drdy && waited < bound) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
        n_checks++; if (stop_osc !== 5'h1F) begin n_fail++; $display("FAIL reset_stop_osc: got %h want 1f", stop_osc); end
        n_checks++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL reset_drdy: got %b want 0", drdy); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL reset_scan_done: got %b want 0", scan_done); end
        n_checks++; if (px_addr !== 5'd0) begin n_fail++; $display("FAIL reset_px_addr: got %0d want 0", px_addr); end
        n_checks++; if (px_count !== 16'd0) begin n_fail++; $display("FAIL reset_px_count: got %0d want 0", px_count); end
        pulse_ack(); pulse_ack();
        n_checks++; if (drdy !== 1'b0 || busy !== 1'b0 || stop_osc !== 5'h1F) begin
            n_fail++; $display("FAIL idle_rd_ack: drdy=%b busy=%b stop_osc=%h want 0 0 1f", drdy, busy, stop_osc);
        end
    endtask

    task automatic test_single();
        int   w;
        exp_t e;
        single_en = 1'b1; single_addr = 5'd3; gate_len = 16'd100; cont_en = 1'b0;
        px_period = 10; px_mask = '0; px_mask[3] = 1'b1;
        e.addr = 5'd3; e.cnt = 10; sb.push_back(e);
        pulse_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        n_checks++; if (stop_osc !== 5'd3) begin n_fail++; $display("FAIL single_settle_osc: got %0d want 3", stop_osc); end
        single_addr = 5'd7; gate_len = 16'd5;  // must not affect the running scan
        cyc(20);
        n_checks++; if (stop_osc !== 5'd3) begin n_fail++; $display("FAIL single_measure_osc: got %0d want 3", stop_osc); end
        n_checks++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL single_gate_latched: drdy got %b want 0", drdy); end
        wait_drdy(300, w);
        n_checks++;
        if (w >= 300) begin
            n_fail++; $display("FAIL single_drdy_timeout: waited %0d want <300", w);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        n_checks++; if (px_addr !== e.addr) begin n_fail++; $display("FAIL single_px_addr: got %0d want %0d", px_addr, e.addr); end
        n_checks++; if ($isunknown(px_count) || int'(px_count) < e.cnt - 1 || int'(px_count) > e.cnt + 1) begin
            n_fail++; $display("FAIL single_px_count: got %0d want %0d+/-1", px_count, e.cnt);
        end
        n_checks++; if (stop_osc !== 5'h1F) begin n_fail++; $display("FAIL single_wait_osc: got %h want 1f", stop_osc); end
        cyc(2);
        n_checks++; if (drdy !== 1'b1) begin n_fail++; $display("FAIL single_drdy_held: got %b want 1", drdy); end
        pulse_ack();
        n_checks++; if (drdy !== 1'b0 || scan_done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_done: drdy=%b scan_done=%b busy=%b want 0 1 0", drdy, scan_done, busy);
        end
        cyc(1);
        n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b want 0", scan_done); end

        // out-of-range address falls back to pixel 0; zero gate behaves as one cycle
        single_addr = 5'd25; gate_len = 16'd0;
        pulse_start();
        wait_drdy(50, w);
        n_checks++; if (w !== 9) begin n_fail++; $display("FAIL gate0_latency: got %0d want 9", w); end
        n_checks++; if (px_addr !== 5'd0) begin n_fail++; $display("FAIL oob_px_addr: got %0d want 0", px_addr); end
        n_checks++; if (px_count !== 16'd0) begin n_fail++; $display("FAIL gate0_px_count: got %0d want 0", px_count); end
        pulse_ack();
        n_checks++; if (scan_done !== 1'b1) begin n_fail++; $display("FAIL gate0_scan_done: got %b want 1", scan_done); end
        cyc(1);
    endtask

    task automatic test_full_scan();
        int   w;
        exp_t e;
        single_en = 1'b0; cont_en = 1'b0; gate_len = 16'd50;
        px_period = 5; px_mask = '1;
        for (int i = 0; i < 19; i++) begin
            e.addr = 5'(i); e.cnt = 10; sb.push_back(e);
        end
        pulse_start();
        for (int i = 0; i < 19; i++) begin
            wait_drdy(200, w);
            n_checks++;
            if (w >= 200) begin
                n_fail++; $display("FAIL full_drdy_timeout: pixel %0d waited %0d want <200", i, w);
                sb.delete();
                abort = 1'b1; cyc(1); abort = 1'b0;
                return;
            end
            e = sb.pop_front();
            n_checks++; if (px_addr !== e.addr) begin n_fail++; $display("FAIL full_px_addr: got %0d want %0d", px_addr, e.addr); end
            n_checks++; if ($isunknown(px_count) || int'(px_count) < e.cnt - 1 || int'(px_count) > e.cnt + 1) begin
                n_fail++; $display("FAIL full_px_count: pixel %0d got %0d want %0d+/-1", i, px_count, e.cnt);
            end
            n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL full_early_done: pixel %0d got %b want 0", i, scan_done); end
            cyc(3);
            pulse_ack();
        end
        n_checks++; if (scan_done !== 1'b1 || busy !== 1'b0 || stop_osc !== 5'h1F) begin
            n_fail++; $display("FAIL full_end: scan_done=%b busy=%b stop_osc=%h want 1 0 1f", scan_done, busy, stop_osc);
        end
        cyc(1);
        n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL full_done_pulse: got %b want 0", scan_done); end
    endtask

    task automatic test_cont_wrap();
        int   w;
        exp_t e;
        single_en = 1'b0; cont_en = 1'b1; gate_len = 16'd50;
        px_period = 5; px_mask = '1;
        for (int i = 0; i < 20; i++) begin
            e.addr = 5'(i % 19); e.cnt = 10; sb.push_back(e);
        end
        pulse_start();
        cont_en = 1'b0;  // latched at start: the scan must still wrap
        for (int i = 0; i < 20; i++) begin
            wait_drdy(200, w);
            n_checks++;
            if (w >= 200) begin
                n_fail++; $display("FAIL cont_drdy_timeout: step %0d waited %0d want <200", i, w);
                sb.delete();
                abort = 1'b1; cyc(1); abort = 1'b0;
                return;
            end
            e = sb.pop_front();
            n_checks++; if (px_addr !== e.addr) begin n_fail++; $display("FAIL cont_px_addr: got %0d want %0d", px_addr, e.addr); end
            n_checks++; if ($isunknown(px_count) || int'(px_count) < e.cnt - 1 || int'(px_count) > e.cnt + 1) begin
                n_fail++; $display("FAIL cont_px_count: step %0d got %0d want %0d+/-1", i, px_count, e.cnt);
            end
            if (i == 18) begin
                cyc(200);
                n_checks++; if (drdy !== 1'b1 || stop_osc !== 5'h1F || busy !== 1'b1) begin
                    n_fail++; $display("FAIL cont_stall: drdy=%b stop_osc=%h busy=%b want 1 1f 1", drdy, stop_osc, busy);
                end
                pulse_ack();
                n_checks++; if (scan_done !== 1'b0 || stop_osc !== 5'd0 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL cont_wrap: scan_done=%b stop_osc=%0d busy=%b want 0 0 1", scan_done, stop_osc, busy);
                end
            end else if (i == 19) begin
                abort = 1'b1; rd_ack = 1'b1; @(negedge clk); abort = 1'b0; rd_ack = 1'b0;
                n_checks++; if (busy !== 1'b0 || drdy !== 1'b0 || stop_osc !== 5'h1F || scan_done !== 1'b0) begin
                    n_fail++; $display("FAIL abort_ack: busy=%b drdy=%b stop_osc=%h scan_done=%b want 0 0 1f 0", busy, drdy, stop_osc, scan_done);
                end
                cyc(1);
                n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL abort_ack_done: got %b want 0", scan_done); end
            end else begin
                cyc(1);
                pulse_ack();
            end
        end
    endtask

    task automatic test_abort_rst();
        int   w;
        exp_t e;
        single_en = 1'b0; cont_en = 1'b0; gate_len = 16'd50;
        px_period = 5; px_mask = '1;
        pulse_start();
        cyc(20);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || stop_osc !== 5'h1F || drdy !== 1'b0) begin
            n_fail++; $display("FAIL abort_measure: busy=%b stop_osc=%h drdy=%b want 0 1f 0", busy, stop_osc, drdy);
        end
        cyc(80);
        n_checks++; if (drdy !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_discard: drdy=%b busy=%b want 0 0", drdy, busy);
        end

        e.addr = 5'd0; e.cnt = 10; sb.push_back(e);
        pulse_start();
        n_checks++; if (stop_osc !== 5'd0) begin n_fail++; $display("FAIL restart_osc: got %0d want 0", stop_osc); end
        wait_drdy(200, w);
        n_checks++; if (w >= 200) begin n_fail++; $display("FAIL restart_timeout: waited %0d want <200", w); end
        e = sb.pop_front();
        n_checks++; if (px_addr !== e.addr) begin n_fail++; $display("FAIL restart_px_addr: got %0d want %0d", px_addr, e.addr); end
        pulse_ack();
        cyc(20);
        n_checks++; if (stop_osc !== 5'd1) begin n_fail++; $display("FAIL next_px_osc: got %0d want 1", stop_osc); end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        n_checks++; if (stop_osc !== 5'h1F || busy !== 1'b0 || drdy !== 1'b0 || scan_done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: stop_osc=%h busy=%b drdy=%b scan_done=%b want 1f 0 0 0", stop_osc, busy, drdy, scan_done);
        end
        n_checks++; if (px_addr !== 5'd0 || px_count !== 16'd0) begin
            n_fail++; $display("FAIL rst_mid_result: px_addr=%0d px_count=%0d want 0 0", px_addr, px_count);
        end

        e.addr = 5'd0; e.cnt = 10; sb.push_back(e);
        pulse_start();
        wait_drdy(200, w);
        n_checks++; if (w >= 200) begin n_fail++; $display("FAIL rst_restart_timeout: waited %0d want <200", w); end
        e = sb.pop_front();
        n_checks++; if (px_addr !== e.addr) begin n_fail++; $display("FAIL rst_restart_px_addr: got %0d want %0d", px_addr, e.addr); end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
    endtask

    task automatic test_saturation();
        int   w;
        exp_t e;
        single_en = 1'b1; single_addr = 5'd5; gate_len = 16'd200; cont_en = 1'b0;
        px_period = 4; px_mask = '0; px_mask[5] = 1'b1;
        e.addr = 5'd5; e.cnt = 15; sb.push_back(e);
        s_start = 1'b1; @(negedge clk); s_start = 1'b0;
        n_checks++; if (s_stop_osc !== 5'd5 || s_busy !== 1'b1) begin
            n_fail++; $display("FAIL sat_start: stop_osc=%0d busy=%b want 5 1", s_stop_osc, s_busy);
        end
        w = 0;
        while (!s_drdy && w < 400) begin @(negedge clk); w++; end
        n_checks++; if (w >= 400) begin n_fail++; $display("FAIL sat_timeout: waited %0d want <400", w); end
        e = sb.pop_front();
        n_checks++; if (s_px_addr !== e.addr) begin n_fail++; $display("FAIL sat_px_addr: got %0d want %0d", s_px_addr, e.addr); end
        n_checks++; if (int'(s_px_count) !== e.cnt) begin n_fail++; $display("FAIL sat_px_count: got %0d want %0d", s_px_count, e.cnt); end
        s_rd_ack = 1'b1; @(negedge clk); s_rd_ack = 1'b0;
        n_checks++; if (s_scan_done !== 1'b1 || s_busy !== 1'b0) begin
            n_fail++; $display("FAIL sat_done: scan_done=%b busy=%b want 1 0", s_scan_done, s_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_scan();
        test_cont_wrap();
        test_abort_rst();
        test_saturation();
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
